// File: rtl/core_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | core_pkg : shared types and field constants for the 9-bit core       |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package core_pkg;

    localparam int INSTR_W = 9;
    localparam int OPC_HI  = 8;
    localparam int OPC_LO  = 6;
    localparam int BOFF_W  = 6;

    typedef enum logic [2:0] {
        OP_ADD    = 3'd0,
        OP_SHIFT  = 3'd1,
        OP_LOAD   = 3'd2,
        OP_STORE  = 3'd3,
        OP_LOGIC  = 3'd4,
        OP_BRANCH = 3'd5,
        OP_MOV    = 3'd6,
        OP_HALT   = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALTED = 2'd3
    } state_e;

    function automatic opcode_e getOpcode(input logic [INSTR_W-1:0] code);
        return opcode_e'(code[OPC_HI:OPC_LO]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_decode : combinational opcode -> control strobe decode         |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module instr_decode
    import core_pkg::*;
(
    input  logic [INSTR_W-1:0] machCode,
    input  logic               exValid,
    output logic               isShift,
    output logic               isAdd,
    output logic               isBranch,
    output logic               regWrite,
    output logic               memRead,
    output logic               memWrite
);

    always_comb begin
        isShift  = 1'b0;
        isAdd    = 1'b0;
        isBranch = 1'b0;
        regWrite = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
        if (exValid) begin
            case (getOpcode(machCode))
                OP_ADD:    begin isAdd = 1'b1;   regWrite = 1'b1; end
                OP_SHIFT:  begin isShift = 1'b1; regWrite = 1'b1; end
                OP_LOAD:   begin memRead = 1'b1; regWrite = 1'b1; end
                OP_STORE:  memWrite = 1'b1;
                OP_LOGIC:  regWrite = 1'b1;
                OP_BRANCH: isBranch = 1'b1;
                OP_MOV:    regWrite = 1'b1;
                OP_HALT:   ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_fetch_decode : PC, fetch register, two-cycle FETCH/EXEC control |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module instr_fetch_decode
    import core_pkg::*;
#(
    parameter int          PC_W     = 8,
    parameter int unsigned START_PC = 0,
    parameter int          CNT_W    = 16
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               Start,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               zero_flag,
    input  logic               stall,
    output logic [PC_W-1:0]    imem_addr,
    output logic [INSTR_W-1:0] mach_code,
    output logic               isShift,
    output logic               isAdd,
    output logic               isBranch,
    output logic               regWrite,
    output logic               memRead,
    output logic               memWrite,
    output logic               ex_valid,
    output logic               Done,
    output logic [CNT_W-1:0]   instr_count
);

    localparam logic [PC_W-1:0] c_startPc = PC_W'(START_PC);

    state_e              r_state, w_nextState;
    logic [PC_W-1:0]     r_pc, w_nextPc;
    logic [INSTR_W-1:0]  r_machCode, w_nextCode;
    logic [CNT_W-1:0]    r_count, w_nextCount;
    logic [CNT_W-1:0]    w_countInc;
    logic [PC_W-1:0]     w_branchOff;
    logic                w_exValid;
    opcode_e             w_opcode;

    assign w_exValid   = (r_state == ST_EXEC);
    assign w_opcode    = getOpcode(r_machCode);
    assign w_branchOff = {{(PC_W-BOFF_W){r_machCode[BOFF_W-1]}}, r_machCode[BOFF_W-1:0]};
    // Counter sticks at all-ones rather than wrapping
    assign w_countInc  = (r_count == {CNT_W{1'b1}}) ? r_count : r_count + CNT_W'(1);

    always_comb begin
        w_nextState = r_state;
        w_nextPc    = r_pc;
        w_nextCode  = r_machCode;
        w_nextCount = r_count;
        case (r_state)
            ST_IDLE: begin
                if (Start) begin
                    w_nextPc    = c_startPc;
                    w_nextState = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_nextCode  = imem_data;
                w_nextState = ST_EXEC;
            end
            ST_EXEC: begin
                if (!stall) begin
                    w_nextCount = w_countInc;
                    if (w_opcode == OP_HALT) begin
                        w_nextState = ST_HALTED;
                    end else begin
                        w_nextState = ST_FETCH;
                        if (w_opcode == OP_BRANCH && zero_flag)
                            w_nextPc = r_pc + w_branchOff;
                        else
                            w_nextPc = r_pc + PC_W'(1);
                    end
                end
            end
            ST_HALTED: begin
                if (Start) begin
                    w_nextCount = '0;
                    w_nextPc    = c_startPc;
                    w_nextState = ST_FETCH;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state    <= ST_IDLE;
            r_pc       <= c_startPc;
            r_machCode <= '0;
            r_count    <= '0;
        end else begin
            r_state    <= w_nextState;
            r_pc       <= w_nextPc;
            r_machCode <= w_nextCode;
            r_count    <= w_nextCount;
        end
    end

    instr_decode u_decode (
        .machCode (r_machCode),
        .exValid  (w_exValid),
        .isShift  (isShift),
        .isAdd    (isAdd),
        .isBranch (isBranch),
        .regWrite (regWrite),
        .memRead  (memRead),
        .memWrite (memWrite)
    );

    assign imem_addr   = r_pc;
    assign mach_code   = r_machCode;
    assign ex_valid    = w_exValid;
    assign Done        = (r_state == ST_HALTED);
    assign instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_instr_fetch_decode : randomized bench with instruction-level model |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_instr_fetch_decode;

    logic       Clk, Reset_n, Start, zeroFlag, stall;
    logic [8:0] mem [256];

    logic [7:0]  imemAddr, imemAddr2;
    logic [8:0]  imemData, imemData2, machCode, machCode2;
    logic        isShift, isAdd, isBranch, regWrite, memRead, memWrite, exValid, done;
    logic        isShift2, isAdd2, isBranch2, regWrite2, memRead2, memWrite2, exValid2, done2;
    logic [15:0] instrCount;
    logic [1:0]  instrCount2;

    assign imemData  = mem[imemAddr];
    assign imemData2 = mem[imemAddr2];

    instr_fetch_decode #(.PC_W(8), .START_PC(0), .CNT_W(16)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .imem_data(imemData),
        .zero_flag(zeroFlag), .stall(stall), .imem_addr(imemAddr), .mach_code(machCode),
        .isShift(isShift), .isAdd(isAdd), .isBranch(isBranch), .regWrite(regWrite),
        .memRead(memRead), .memWrite(memWrite), .ex_valid(exValid), .Done(done),
        .instr_count(instrCount)
    );

    instr_fetch_decode #(.PC_W(8), .START_PC(0), .CNT_W(2)) dutSat (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .imem_data(imemData2),
        .zero_flag(zeroFlag), .stall(stall), .imem_addr(imemAddr2), .mach_code(machCode2),
        .isShift(isShift2), .isAdd(isAdd2), .isBranch(isBranch2), .regWrite(regWrite2),
        .memRead(memRead2), .memWrite(memWrite2), .ex_valid(exValid2), .Done(done2),
        .instr_count(instrCount2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int passCnt  = 0;
    int totalCnt = 0;

    // Architectural model: PC, retired count, halted flag
    int mPc;
    int mRaw;
    bit mDone;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalCnt++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        else
            passCnt++;
    endtask

    // {isAdd,isShift,isBranch,regWrite,memRead,memWrite} straight from the opcode table
    function automatic logic [5:0] expStrobes(input logic [2:0] op);
        logic [5:0] t [8];
        t[0] = 6'b100100; t[1] = 6'b010100; t[2] = 6'b000110; t[3] = 6'b000001;
        t[4] = 6'b000100; t[5] = 6'b001000; t[6] = 6'b000100; t[7] = 6'b000000;
        return t[op];
    endfunction

    function automatic logic [5:0] gotStrobes();
        return {isAdd, isShift, isBranch, regWrite, memRead, memWrite};
    endfunction

    function automatic int satCount(input int raw, input int maxv);
        return (raw > maxv) ? maxv : raw;
    endfunction

    task automatic chkArch(input string tag);
        chk({tag, ".addr"},   imemAddr, mPc);
        chk({tag, ".count"},  instrCount, satCount(mRaw, 65535));
        chk({tag, ".done"},   done, mDone);
        chk({tag, ".addr2"},  imemAddr2, mPc);
        chk({tag, ".count2"}, instrCount2, satCount(mRaw, 3));
    endtask

    task automatic chkQuiet(input string tag);
        chk({tag, ".exValid"}, exValid, 1'b0);
        chk({tag, ".strobes"}, gotStrobes(), 6'b0);
    endtask

    // Called at a negedge while idle or halted; returns at the negedge in FETCH
    task automatic startProgram();
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        if (mDone) mRaw = 0;
        mDone = 1'b0;
        mPc   = 0;
        chkArch("start");
        chkQuiet("start");
    endtask

    // Called at a FETCH negedge; runs one instruction and returns at the next negedge
    task automatic execInstr(input int nStall, input bit zf, input bit noise);
        logic [8:0] code;
        logic [5:0] exp;
        int         off;
        code     = mem[mPc];
        exp      = expStrobes(code[8:6]);
        zeroFlag = zf;
        @(negedge Clk);
        for (int i = 0; i <= nStall; i++) begin
            if (i > 0) @(negedge Clk);
            chk("exec.code",    machCode, code);
            chk("exec.exValid", exValid, 1'b1);
            chk("exec.strobes", gotStrobes(), exp);
            chkArch("exec");
            stall = (i < nStall);
            Start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        @(negedge Clk);
        Start = 1'b0;
        stall = 1'b0;
        mRaw++;
        if (code[8:6] == 3'd7) begin
            mDone = 1'b1;
        end else if (code[8:6] == 3'd5 && zf) begin
            off = int'(code[5:0]);
            if (off >= 32) off -= 64;
            mPc = (mPc + off + 256) % 256;
        end else begin
            mPc = (mPc + 1) % 256;
        end
        chkArch("retire");
        chkQuiet("retire");
    endtask

    function automatic logic [8:0] randPlain();
        logic [2:0] ops [6];
        ops[0] = 3'd0; ops[1] = 3'd1; ops[2] = 3'd2;
        ops[3] = 3'd3; ops[4] = 3'd4; ops[5] = 3'd6;
        return {ops[$urandom_range(0, 5)], 6'($urandom)};
    endfunction

    initial begin
        bit taken;
        Reset_n  = 1'b0;
        Start    = 1'b0;
        stall    = 1'b0;
        zeroFlag = 1'b0;
        mPc = 0; mRaw = 0; mDone = 1'b0;
        for (int a = 0; a < 256; a++) mem[a] = randPlain();
        mem[0]   = 9'b000_000001;
        mem[1]   = 9'b001_000011;
        mem[10]  = 9'b101_111100;
        mem[255] = 9'b000_000111;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        chkArch("reset");
        chkQuiet("reset");
        chk("reset.code", machCode, 9'h000);

        // Sequential run with a backward branch at 10, then through the PC wrap
        startProgram();
        taken = 1'b0;
        for (int n = 0; n < 280; n++) begin
            bit zf;
            int ns;
            zf = (mPc == 10) ? !taken : 1'($urandom_range(0, 1));
            if (mPc == 10 && !taken) taken = 1'b1;
            ns = (mPc == 1) ? 3 : $urandom_range(0, 2);
            execInstr(ns, zf, 1'b0);
        end

        // Reset during a STORE in EXEC discards it
        mem[mPc] = {3'b011, 6'($urandom)};
        @(negedge Clk);
        chk("rstExec.memWrite", memWrite, 1'b1);
        Reset_n = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        mPc = 0; mRaw = 0; mDone = 1'b0;
        chk("rstExec.memWriteLow", memWrite, 1'b0);
        chk("rstExec.code", machCode, 9'h000);
        chkArch("rstExec");
        @(negedge Clk);
        chkQuiet("rstIdle");
        chkArch("rstIdle");

        // Halt after six instructions, sit halted, then restart
        for (int a = 0; a < 5; a++) mem[a] = randPlain();
        mem[5] = 9'b111_000000;
        startProgram();
        for (int n = 0; n < 6; n++) execInstr($urandom_range(0, 1), 1'($urandom_range(0, 1)), 1'b0);
        repeat (3) begin
            @(negedge Clk);
            chkArch("halted");
            chkQuiet("halted");
        end
        startProgram();

        // Fully random programs including branches and halts
        for (int a = 0; a < 256; a++) mem[a] = 9'($urandom);
        for (int n = 0; n < 300; n++) begin
            if (mDone) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge Clk);
                    chkArch("rndHalted");
                    chkQuiet("rndHalted");
                end
                startProgram();
            end else begin
                execInstr($urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b1);
            end
        end

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
`default_nettype wire
